// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and timing constants for the character LCD path
package lcd_pkg;

    localparam int LCD_CHAR_W        = 8;
    localparam int LCD_LINE_LEN      = 16;
    localparam int LCD_BUSY_TIMEOUT  = 8;
    // Controller-imposed gap between consecutive character writes, in clocks.
    localparam int LCD_WRITE_SPACING = 2100;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers and synchronous flush
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Flush wins over a same-cycle push so a flushed producer byte never lands.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/lcd_char_feeder.sv
// rtl/lcd_char_feeder.sv - buffers producer bytes and paces them into the LCD controller
module lcd_char_feeder
    import lcd_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int LINE_LEN     = LCD_LINE_LEN,
    parameter int BUSY_TIMEOUT = LCD_BUSY_TIMEOUT
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          iValid,
    input  logic [LCD_CHAR_W-1:0]         iChar,
    output logic                          oAccept,
    input  logic                          iFlush,
    input  logic                          iLCD_Initialized,
    input  logic                          iLCD_Ready,
    output logic                          oLCD_Write,
    output logic [LCD_CHAR_W-1:0]         oLCD_Data,
    output logic [$clog2(LINE_LEN)-1:0]   oColumn,
    output logic [$clog2(DEPTH):0]        oLevel,
    output logic                          oError
);
    localparam int CW = $clog2(LINE_LEN);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    feeder_state_e         state_q, state_d;
    logic                  wr_q, wr_d;
    logic [LCD_CHAR_W-1:0] data_q, data_d;
    logic [CW-1:0]         col_q, col_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LCD_CHAR_W-1:0] fifo_head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LCD_CHAR_W)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .flush_i (iFlush),
        .push_i  (iValid),
        .data_i  (iChar),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (oLevel)
    );

    assign oAccept    = !fifo_full;
    assign oLCD_Write = wr_q;
    assign oLCD_Data  = data_q;
    assign oColumn    = col_q;
    assign oError     = err_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = 1'b0;
        data_d   = data_q;
        col_d    = col_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        if (!iLCD_Initialized) begin
            state_d = S_WAIT_INIT;
        end else begin
            case (state_q)
                S_WAIT_INIT: state_d = S_IDLE;
                S_IDLE: begin
                    if (!fifo_empty && iLCD_Ready) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_head;
                        wr_d     = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_d   = '0;
                    state_d = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!iLCD_Ready) begin
                        col_d   = (col_q == CW'(LINE_LEN - 1)) ? '0 : col_q + 1'b1;
                        state_d = S_WAIT_DONE;
                    end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                        // Controller never went busy: resend the held byte.
                        err_d   = 1'b1;
                        wr_d    = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (iLCD_Ready) state_d = S_IDLE;
                end
                default: state_d = S_WAIT_INIT;
            endcase
        end
        if (iFlush) col_d = '0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_WAIT_INIT;
            wr_q    <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            col_q   <= col_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb/tb_lcd_char_feeder.sv - scoreboard bench with an LCD controller model for lcd_char_feeder
module tb_lcd_char_feeder;
    import lcd_pkg::*;

    localparam int DEPTH        = 16;
    localparam int LINE_LEN     = 16;
    localparam int BUSY_TIMEOUT = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iValid = 1'b0;
    logic [7:0] iChar = 8'h00;
    logic       iFlush = 1'b0;
    logic       iLCD_Initialized = 1'b0;
    logic       ready = 1'b1;
    logic       oAccept;
    logic       oLCD_Write;
    logic [7:0] oLCD_Data;
    logic [3:0] oColumn;
    logic [4:0] oLevel;
    logic       oError;

    lcd_char_feeder #(
        .DEPTH        (DEPTH),
        .LINE_LEN     (LINE_LEN),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iValid           (iValid),
        .iChar            (iChar),
        .oAccept          (oAccept),
        .iFlush           (iFlush),
        .iLCD_Initialized (iLCD_Initialized),
        .iLCD_Ready       (ready),
        .oLCD_Write       (oLCD_Write),
        .oLCD_Data        (oLCD_Data),
        .oColumn          (oColumn),
        .oLevel           (oLevel),
        .oError           (oError)
    );

    always #10 Clock = ~Clock;

    int checks = 0;
    int passes = 0;

    byte unsigned exp_q[$];
    logic [7:0]   last_byte = 8'h00;
    bit           reissue_pending = 1'b0;
    bit           prev_wr = 1'b0;
    int           cyc = 0;
    int           last_wr_cyc = 0;
    int           wr_count = 0;
    int           col_model = 0;
    bit           err_model = 1'b0;
    int           busy_left = 0;
    int           busy_min = 10;
    int           busy_max = 10;
    bit           ctl_hold_low = 1'b0;
    bit           rand_ignore = 1'b0;
    int           force_ignore_cnt = 0;
    int           force_ignore_used = 0;
    int           flush_cnt = 0;
    int           flush_seen = 0;
    bit           hello_mode = 1'b0;
    bit           spacing_armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor followed by the controller model, sequenced in one block.
    always @(negedge Clock) begin
        bit ignore;
        cyc++;
        if (Reset) begin
            ready           = 1'b1;
            busy_left       = 0;
            exp_q.delete();
            reissue_pending = 1'b0;
            col_model       = 0;
            err_model       = 1'b0;
            prev_wr         = 1'b0;
        end else begin
            if (flush_cnt != flush_seen) begin
                flush_seen = flush_cnt;
                exp_q.delete();
                col_model = 0;
            end
            if (oLCD_Write) begin
                wr_count++;
                check("pulse_width", {31'd0, prev_wr}, 32'd0);
                ignore = 1'b0;
                if (reissue_pending) begin
                    check("reissue_data", {24'd0, oLCD_Data}, {24'd0, last_byte});
                    check("reissue_gap", cyc - last_wr_cyc, BUSY_TIMEOUT + 1);
                    check("error_on_timeout", {31'd0, oError}, 32'd1);
                    reissue_pending = 1'b0;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got 0x%0h with nothing queued", oLCD_Data);
                end else begin
                    last_byte = exp_q.pop_front();
                    check("data", {24'd0, oLCD_Data}, {24'd0, last_byte});
                    check("column", {28'd0, oColumn}, col_model);
                    if (hello_mode && spacing_armed)
                        check("spacing", {31'd0, (cyc - last_wr_cyc) >= LCD_WRITE_SPACING}, 32'd1);
                    spacing_armed = hello_mode;
                    if (force_ignore_cnt != force_ignore_used) begin
                        force_ignore_used = force_ignore_cnt;
                        ignore = 1'b1;
                    end else if (rand_ignore && $urandom_range(7) == 0) begin
                        ignore = 1'b1;
                    end
                end
                last_wr_cyc = cyc;
                if (ready) begin
                    if (ignore) begin
                        reissue_pending = 1'b1;
                        err_model       = 1'b1;
                    end else begin
                        ready     = 1'b0;
                        busy_left = $urandom_range(busy_max, busy_min);
                        col_model = (col_model + 1) % LINE_LEN;
                    end
                end
            end else if (ctl_hold_low) begin
                ready = 1'b0;
            end else if (!ready) begin
                if (busy_left > 0) busy_left--;
                else ready = 1'b1;
            end
            prev_wr = oLCD_Write;
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge Clock);
        iValid = 1'b1;
        iChar  = c;
        while (!oAccept && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within %0d cycles", c, n);
        end else begin
            exp_q.push_back(c);
            @(posedge Clock);
            #1;
        end
        iValid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || reissue_pending || !ready || ctl_hold_low) && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        repeat (4) @(negedge Clock);
        if (n >= 20000) begin
            checks++;
            $display("FAIL %s: drain did not finish, %0d bytes still queued", name, exp_q.size());
        end
    endtask

    initial begin
        int w0;
        int n;
        int rel;
        byte unsigned hello[5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        repeat (3) @(negedge Clock);
        check("rst_write", {31'd0, oLCD_Write}, 32'd0);
        check("rst_data", {24'd0, oLCD_Data}, 32'd0);
        check("rst_column", {28'd0, oColumn}, 32'd0);
        check("rst_level", {27'd0, oLevel}, 32'd0);
        check("rst_error", {31'd0, oError}, 32'd0);
        check("rst_accept", {31'd0, oAccept}, 32'd1);
        Reset = 1'b0;

        // Nothing may be issued until the controller reports initialised.
        w0 = wr_count;
        send(8'h41);
        repeat (100) @(negedge Clock);
        check("init_gate_writes", wr_count, w0);
        check("init_gate_level", {27'd0, oLevel}, 32'd1);
        iLCD_Initialized = 1'b1;
        wait_drain("init_drain");
        check("init_one_write", wr_count, w0 + 1);
        check("init_level", {27'd0, oLevel}, 32'd0);

        busy_min = LCD_WRITE_SPACING;
        busy_max = LCD_WRITE_SPACING;
        hello_mode = 1'b1;
        spacing_armed = 1'b0;
        foreach (hello[i]) send(hello[i]);
        wait_drain("hello_drain");
        hello_mode = 1'b0;
        check("hello_column", {28'd0, oColumn}, 32'd6);

        busy_min = 10;
        busy_max = 10;
        check("error_before_timeout", {31'd0, oError}, 32'd0);
        force_ignore_cnt++;
        send(8'h5A);
        wait_drain("timeout_drain");
        check("error_sticky", {31'd0, oError}, 32'd1);
        check("timeout_column", {28'd0, oColumn}, 32'd7);

        // Flush while the in-flight byte waits for busy.
        ctl_hold_low = 1'b1;
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 6; i++) send(8'h60 + 8'(i));
        check("flush_prefill", {27'd0, oLevel}, 32'd6);
        w0 = wr_count;
        ctl_hold_low = 1'b0;
        n = 0;
        while (!oLCD_Write && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        check("flush_level_before", {27'd0, oLevel}, 32'd5);
        iFlush = 1'b1;
        flush_cnt++;
        @(posedge Clock);
        #1;
        iFlush = 1'b0;
        check("flush_level", {27'd0, oLevel}, 32'd0);
        check("flush_column", {28'd0, oColumn}, 32'd0);
        wait_drain("flush_drain");
        check("flush_inflight_only", wr_count, w0 + 1);
        check("flush_column_after", {28'd0, oColumn}, 32'd0);

        // Fill to full with the controller held busy, then release.
        ctl_hold_low = 1'b1;
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        check("full_accept", {31'd0, oAccept}, 32'd0);
        check("full_level", {27'd0, oLevel}, 32'd16);
        rel = 0;
        fork
            send(8'h40);
            begin
                repeat (3) @(negedge Clock);
                rel = cyc;
                ctl_hold_low = 1'b0;
            end
        join
        check("accept_on_first_pop", {31'd0, (cyc - rel) <= 4}, 32'd1);
        wait_drain("full_drain");
        check("wrap_column", {28'd0, oColumn}, 32'd1);
        check("wrap_level", {27'd0, oLevel}, 32'd0);

        busy_min = 2;
        busy_max = 40;
        rand_ignore = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(3)) @(negedge Clock);
        end
        wait_drain("random_drain");
        rand_ignore = 1'b0;
        check("random_column", {28'd0, oColumn}, col_model);
        check("random_level", {27'd0, oLevel}, 32'd0);
        check("random_error", {31'd0, oError}, {31'd0, err_model});

        // Asynchronous reset while the controller is busy with a character.
        busy_min = 50;
        busy_max = 50;
        send(8'h71);
        send(8'h72);
        send(8'h73);
        n = 0;
        while (!oLCD_Write && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        @(posedge Clock);
        #5;
        Reset = 1'b1;
        #1;
        check("async_rst_write", {31'd0, oLCD_Write}, 32'd0);
        check("async_rst_error", {31'd0, oError}, 32'd0);
        check("async_rst_level", {27'd0, oLevel}, 32'd0);
        check("async_rst_column", {28'd0, oColumn}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);
        check("post_rst_idle", {31'd0, oLCD_Write}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
